// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit : PC register plus req/ack fetch FSM feeding the op decoder
// Revision 1.0
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      fault_q    <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          wait_cnt_d = 8'd0;
          state_d    = S_EXEC;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (!pc_src) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end else if (pc_target[1:0] == 2'b00) begin
            pc_d    = pc_target;
            state_d = S_FETCH;
          end else begin
            // Misaligned target: keep the faulting instruction's PC for debug
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Request is masked while reset is held so it rises only on release
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = (state_q == S_EXEC);
  assign fetch_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// Testbench for inst_fetch_unit: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_inst_fetch_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .instr(instr), .op(op), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault)
  );

  // Model: phase 0 = waiting for a word, 1 = word on display, 2 = dead
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;
  int          m_unacked;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase   <= 0;
      m_pc      <= 32'h0;
      m_instr   <= 32'h13;
      m_fault   <= 1'b0;
      m_unacked <= 0;
    end else if (m_phase == 0) begin
      if (imem_ack) begin
        m_instr   <= imem_rdata;
        m_unacked <= 0;
        m_phase   <= 1;
      end else if (m_unacked + 1 >= MAX_WAIT) begin
        m_fault <= 1'b1;
        m_phase <= 2;
      end else begin
        m_unacked <= m_unacked + 1;
      end
    end else if (m_phase == 1 && !stall) begin
      if (!pc_src) begin
        m_pc    <= m_pc + 32'd4;
        m_phase <= 0;
      end else if (pc_target % 4 == 0) begin
        m_pc    <= pc_target;
        m_phase <= 0;
      end else begin
        m_fault <= 1'b1;
        m_phase <= 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_req",    32'(imem_req),    32'(m_phase == 0 && !rst));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("instr",       instr,            m_instr);
      chk("op",          32'(op),          32'(m_instr[6:0]));
      chk("pc",          pc,               m_pc);
      chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == 1));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  // Applies inputs for one clock edge; returns 1 time unit after the next negedge
  task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                       input logic src, input logic [31:0] tgt);
    imem_ack   = ack;
    imem_rdata = rdata;
    stall      = st;
    pc_src     = src;
    pc_target  = tgt;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // T1: reset state, then release
    repeat (2) @(negedge clk);
    #1;
    chk("t1_pc", pc, 32'h0);
    chk("t1_instr", instr, 32'h13);
    chk("t1_valid", 32'(instr_valid), 32'h0);
    chk("t1_fault", 32'(fetch_fault), 32'h0);
    chk("t1_req_in_rst", 32'(imem_req), 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_req_release", 32'(imem_req), 32'h1);
    chk("t1_addr_release", imem_addr, 32'h0);
    cmp_en = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk("t1_mid_fetch_valid", 32'(instr_valid), 32'h0);
    chk("t1_mid_fetch_pc", pc, 32'h0);
    rst = 1'b0;
    #1;

    // T2: sequential stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
      chk("t2_valid", 32'(instr_valid), 32'h1);
      chk("t2_pc", pc, 32'(4 * i));
      chk("t2_op", 32'(op), 32'h13);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t2_valid_low", 32'(instr_valid), 32'h0);
      chk("t2_next_addr", imem_addr, 32'(4 * (i + 1)));
    end

    // T3a: aligned branch from 0x10
    drive(1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'h0);
    chk("t3_pc", pc, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    chk("t3_target_addr", imem_addr, 32'h40);

    // T6: wrap from the top of the address space
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    chk("t6_pc_plus4", pc_plus4, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t6_pc_wrapped", pc, 32'h0);
    chk("t6_no_fault", 32'(fetch_fault), 32'h0);

    // T4: three wait cycles, then four stalled cycles with stray acks
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t4_still_fetch", 32'(imem_req), 32'h1);
    drive(1'b1, 32'hDEAD_BEB7, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_valid", 32'(instr_valid), 32'h1);
      chk("t4_instr_held", instr, 32'hDEAD_BEB7);
      drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h100);
    end
    chk("t4_valid_5th", 32'(instr_valid), 32'h1);
    chk("t4_op", 32'(op), 32'h37);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t4_pc_next", pc, 32'h4);

    // T3b: misaligned branch faults and halts
    drive(1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h42);
    chk("t3_fault", 32'(fetch_fault), 32'h1);
    chk("t3_halt_req", 32'(imem_req), 32'h0);
    chk("t3_pc_kept", pc, 32'h4);
    repeat (3) drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    chk("t3_halt_stays", 32'(imem_req), 32'h0);
    chk("t3_halt_valid", 32'(instr_valid), 32'h0);

    // T5: timeout on the 15th unacknowledged cycle
    do_reset();
    chk("t5_fault_cleared", 32'(fetch_fault), 32'h0);
    repeat (MAX_WAIT - 1) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t5_no_fault_yet", 32'(fetch_fault), 32'h0);
    chk("t5_req_yet", 32'(imem_req), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t5_fault", 32'(fetch_fault), 32'h1);
    chk("t5_req_off", 32'(imem_req), 32'h0);
    do_reset();
    chk("t5_rst_clears", 32'(fetch_fault), 32'h0);

    // Randomized traffic, including long ack droughts and mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      logic        ack;
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      ack = ($urandom_range(0, 2) != 0);
      if (n % 700 > 680) ack = 1'b0;
      drive(ack, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom), tgt);
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
